// File: rtl/fseq_pkg.sv
// fseq_pkg: shared types and constants for the FSM vector sequencer.
// Holds the controller state encoding, the layout of one vector memory
// entry {chk, exp, stim}, and the response-signature MISR constants.
package fseq_pkg;

  localparam int FSEQ_XW    = 7;
  localparam int FSEQ_YW    = 9;
  localparam int FSEQ_DEPTH = 16;
  localparam int FSEQ_AW    = 4;
  localparam int FSEQ_CNTW  = 16;

  // Entry layout, LSB first: stimulus, expected response, check enable.
  localparam int STIM_LSB = 0;
  localparam int EXP_LSB  = STIM_LSB + FSEQ_XW;
  localparam int CHK_BIT  = EXP_LSB + FSEQ_YW;

  // x^16 + x^12 + x^3 + x + 1, Galois form; seeded at every run start.
  localparam logic [15:0] MISR_POLY = 16'h100B;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRST  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    FIN   = 3'd4
  } fseq_state_e;

  // One MISR step: shift, fold the polynomial on MSB carry-out, xor data in.
  function automatic logic [15:0] misr_next(input logic [15:0] sig, input logic [15:0] din);
    logic [15:0] fb;
    fb = sig[15] ? MISR_POLY : 16'h0000;
    return {sig[14:0], 1'b0} ^ fb ^ din;
  endfunction

endpackage

// File: rtl/fseq_vec_mem.sv
// fseq_vec_mem: vector program store. Synchronous write, combinational read.
// Deliberately has no reset so a loaded program survives rst.
module fseq_vec_mem #(
  parameter int AW    = 4,
  parameter int DEPTH = 16,
  parameter int W     = 17
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_r [DEPTH];

  // Write port: one entry per cycle when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/fsm_vector_sequencer.sv
// fsm_vector_sequencer: programmable tester for small benchmark FSMs.
// Resets the FSM under test, streams vectors one per cycle, compares each
// response one cycle after its vector, repeats the program for several
// passes without re-resetting the DUT, and reports pass/fail details.
// Optional build macro FSEQ_MISR_EN adds a 16-bit response signature MISR;
// without it, signature is tied to zero.
module fsm_vector_sequencer
  import fseq_pkg::*;
#(
  parameter int XW    = FSEQ_XW,
  parameter int YW    = FSEQ_YW,
  parameter int DEPTH = FSEQ_DEPTH,
  parameter int AW    = FSEQ_AW,
  parameter int CNTW  = FSEQ_CNTW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [YW+XW:0]   cfg_wdata,
  input  logic [AW:0]      cfg_len,
  input  logic [7:0]       cfg_loops,
  input  logic             cfg_stop_on_fail,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             dut_rst,
  output logic [XW-1:0]    dut_x,
  input  logic [YW-1:0]    dut_y,
  output logic [CNTW-1:0]  fail_cnt,
  output logic [AW-1:0]    first_fail_idx,
  output logic [7:0]       first_fail_loop,
  output logic [15:0]      signature
);

  localparam int EW = 1 + YW + XW;

  fseq_state_e   state_r;
  logic          drst_ph_r;
  logic [AW-1:0] idx_r;
  logic [7:0]    loop_r;
  logic [AW-1:0] len_last_r;
  logic [7:0]    loop_last_r;
  logic          stop_r;
  logic          skip_r;
  logic [YW-1:0] exp_r;
  logic          chk_r;

  logic [AW:0]   len_c_s;
  logic [AW-1:0] len_last_s;
  logic [7:0]    loop_last_s;
  logic [AW-1:0] nidx_s;
  logic [7:0]    nloop_s;
  logic [AW-1:0] rd_addr_s;
  logic [EW-1:0] rd_s;
  logic          last_s;
  logic          cmp_en_s;
  logic          mismatch_s;

  fseq_vec_mem #(.AW(AW), .DEPTH(DEPTH), .W(EW)) u_mem (
    .clk   (clk),
    .we    (cfg_we && (state_r == IDLE)),
    .waddr (cfg_addr),
    .wdata (cfg_wdata),
    .raddr (rd_addr_s),
    .rdata (rd_s)
  );

  // Run parameters as they would be captured on start: clamp length, treat 0 passes as 1.
  always_comb begin
    if (cfg_len > (AW+1)'(DEPTH)) begin
      len_c_s = (AW+1)'(DEPTH);
    end else begin
      len_c_s = cfg_len;
    end
    // Low bits of DEPTH are zero, so DEPTH-1 still comes out right here.
    len_last_s = len_c_s[AW-1:0] - AW'(1);
    if (cfg_loops == 8'd0) begin
      loop_last_s = 8'd0;
    end else begin
      loop_last_s = cfg_loops - 8'd1;
    end
  end

  // Next vector position with wrap into the next pass, and the memory read address.
  always_comb begin
    if (idx_r == len_last_r) begin
      nidx_s  = {AW{1'b0}};
      nloop_s = loop_r + 8'd1;
    end else begin
      nidx_s  = idx_r + AW'(1);
      nloop_s = loop_r;
    end
    if (state_r == RUN) begin
      rd_addr_s = nidx_s;
    end else begin
      rd_addr_s = {AW{1'b0}};
    end
    last_s = (nidx_s == len_last_r) && (nloop_s == loop_last_r);
  end

  // Compare of the in-flight vector; suppressed after a stop-on-fail.
  always_comb begin
    if (((state_r == RUN) || (state_r == DRAIN)) && !skip_r) begin
      cmp_en_s = 1'b1;
    end else begin
      cmp_en_s = 1'b0;
    end
    mismatch_s = cmp_en_s && chk_r && (dut_y != exp_r);
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= IDLE;
      drst_ph_r       <= 1'b0;
      idx_r           <= {AW{1'b0}};
      loop_r          <= 8'd0;
      len_last_r      <= {AW{1'b0}};
      loop_last_r     <= 8'd0;
      stop_r          <= 1'b0;
      skip_r          <= 1'b0;
      exp_r           <= {YW{1'b0}};
      chk_r           <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      dut_rst         <= 1'b1;
      dut_x           <= {XW{1'b0}};
      fail_cnt        <= {CNTW{1'b0}};
      first_fail_idx  <= {AW{1'b0}};
      first_fail_loop <= 8'd0;
    end else begin
      done <= 1'b0;
      if (mismatch_s) begin
        if (fail_cnt != {CNTW{1'b1}}) begin
          fail_cnt <= fail_cnt + CNTW'(1);
        end
        if (fail_cnt == {CNTW{1'b0}}) begin
          first_fail_idx  <= idx_r;
          first_fail_loop <= loop_r;
        end
      end
      case (state_r)
        IDLE: begin
          dut_rst <= 1'b1;
          if (start) begin
            len_last_r      <= len_last_s;
            loop_last_r     <= loop_last_s;
            stop_r          <= cfg_stop_on_fail;
            skip_r          <= 1'b0;
            fail_cnt        <= {CNTW{1'b0}};
            first_fail_idx  <= {AW{1'b0}};
            first_fail_loop <= 8'd0;
            dut_x           <= {XW{1'b0}};
            drst_ph_r       <= 1'b0;
            busy            <= 1'b1;
            if (len_c_s == {(AW+1){1'b0}}) begin
              state_r <= FIN;
              done    <= 1'b1;
              pass    <= 1'b1;
            end else begin
              state_r <= DRST;
              pass    <= 1'b0;
            end
          end
        end
        DRST: begin
          if (abort) begin
            state_r <= FIN;
            done    <= 1'b1;
            pass    <= 1'b0;
          end else if (!drst_ph_r) begin
            drst_ph_r <= 1'b1;
          end else begin
            dut_rst <= 1'b0;
            dut_x   <= rd_s[STIM_LSB +: XW];
            exp_r   <= rd_s[EXP_LSB +: YW];
            chk_r   <= rd_s[CHK_BIT];
            idx_r   <= {AW{1'b0}};
            loop_r  <= 8'd0;
            if ((len_last_r == {AW{1'b0}}) && (loop_last_r == 8'd0)) begin
              state_r <= DRAIN;
            end else begin
              state_r <= RUN;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state_r <= FIN;
            done    <= 1'b1;
            pass    <= 1'b0;
          end else begin
            dut_x  <= rd_s[STIM_LSB +: XW];
            exp_r  <= rd_s[EXP_LSB +: YW];
            chk_r  <= rd_s[CHK_BIT];
            idx_r  <= nidx_s;
            loop_r <= nloop_s;
            if (stop_r && mismatch_s) begin
              // The vector launched on this edge is left uncompared.
              state_r <= DRAIN;
              skip_r  <= 1'b1;
            end else if (last_s) begin
              state_r <= DRAIN;
            end else begin
              state_r <= RUN;
            end
          end
        end
        DRAIN: begin
          state_r <= FIN;
          done    <= 1'b1;
          pass    <= !abort && (fail_cnt == {CNTW{1'b0}}) && !mismatch_s;
        end
        FIN: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          dut_rst <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          dut_rst <= 1'b1;
        end
      endcase
    end
  end

`ifdef FSEQ_MISR_EN
  logic [15:0] sig_r;

  // Signature folds every compared response, checked or not; holds after FIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_r <= 16'h0000;
    end else if ((state_r == IDLE) && start) begin
      sig_r <= MISR_SEED;
    end else if (cmp_en_s) begin
      sig_r <= misr_next(sig_r, {{(16-YW){1'b0}}, dut_y});
    end else begin
      sig_r <= sig_r;
    end
  end

  assign signature = sig_r;
`else
  assign signature = 16'h0000;
`endif

endmodule

// File: tb/tb_fsm_vector_sequencer.sv
// tb_fsm_vector_sequencer: scoreboard bench for the vector sequencer.
// Expected run results are queued when a run is launched and compared when
// the done pulse appears. The FSM under test is modelled in the bench.
module tb_fsm_vector_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [16:0] cfg_wdata;
  logic [4:0]  cfg_len;
  logic [7:0]  cfg_loops;
  logic        cfg_stop_on_fail;
  logic        start;
  logic        abort;
  logic        busy, done, pass, dut_rst;
  logic [6:0]  dut_x;
  logic [8:0]  dut_y;
  logic [15:0] fail_cnt;
  logic [3:0]  first_fail_idx;
  logic [7:0]  first_fail_loop;
  logic [15:0] signature;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [15:0] lat;
    logic        pass;
    logic [15:0] fcnt;
    logic [3:0]  fidx;
    logic [7:0]  floop;
    logic        chkx;
    logic [6:0]  x;
  } exp_t;

  exp_t sb_q[$];

  fsm_vector_sequencer dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_len(cfg_len), .cfg_loops(cfg_loops), .cfg_stop_on_fail(cfg_stop_on_fail),
    .start(start), .abort(abort), .busy(busy), .done(done), .pass(pass),
    .dut_rst(dut_rst), .dut_x(dut_x), .dut_y(dut_y), .fail_cnt(fail_cnt),
    .first_fail_idx(first_fail_idx), .first_fail_loop(first_fail_loop),
    .signature(signature)
  );

  always #5 clk = ~clk;

  // FSM-under-test models; they register on the falling edge.
  logic       troj_mode = 1'b0;
  logic       zero_mode = 1'b0;
  logic [8:0] xor_y_r;
  logic       st_r;
  logic [3:0] s1_cnt_r;

  function automatic logic [8:0] ref_y(input logic [6:0] x);
    return {x[1:0], x} ^ 9'h15A;
  endfunction

  function automatic logic [6:0] stim_of(input int i);
    return 7'((i * 37 + 11) % 128);
  endfunction

  always @(negedge clk) begin
    if (dut_rst) begin
      xor_y_r  <= 9'h000;
      st_r     <= 1'b0;
      s1_cnt_r <= 4'd0;
    end else begin
      xor_y_r <= ref_y(dut_x);
      st_r    <= dut_x[0];
      if (dut_x[0] && (s1_cnt_r != 4'hF)) s1_cnt_r <= s1_cnt_r + 4'd1;
    end
  end

  // Trojan model: s1 output is diverted once s1 has been visited five times.
  assign dut_y = zero_mode ? 9'h000 :
                 troj_mode ? (st_r ? ((s1_cnt_r >= 4'd5) ? 9'h1AA : 9'h0AA) : 9'h055) :
                 xor_y_r;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  task automatic wr(input int a, input logic c, input logic [8:0] e, input logic [6:0] s);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 4'(a); cfg_wdata = {c, e, s};
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic load_ref(input int n);
    for (int i = 0; i < n; i++) wr(i, 1'b1, ref_y(stim_of(i)), stim_of(i));
  endtask

  function automatic exp_t mk(input int lat, input logic p, input int fc, input int fi,
                              input int fl, input logic cx, input logic [6:0] x);
    exp_t e;
    e.lat = 16'(lat); e.pass = p; e.fcnt = 16'(fc); e.fidx = 4'(fi);
    e.floop = 8'(fl); e.chkx = cx; e.x = x;
    return e;
  endfunction

  // Launch a run, track per-cycle behaviour, compare against the queued result at done.
  task automatic run_prog(input logic [4:0] len, input logic [7:0] loops, input logic stop,
                          input int abort_at, input logic poke, input exp_t e);
    int n; logic got_done, prof_bad, busy_bad; exp_t w;
    sb_q.push_back(e);
    @(negedge clk);
    cfg_len = len; cfg_loops = loops; cfg_stop_on_fail = stop; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; got_done = 1'b0; prof_bad = 1'b0; busy_bad = 1'b0;
    while (!got_done && n < 400) begin
      @(negedge clk);
      if (dut_rst !== ((len == 5'd0 || n < 2) ? 1'b1 : 1'b0)) prof_bad = 1'b1;
      if (busy !== 1'b1) busy_bad = 1'b1;
      if (done === 1'b1) begin
        got_done = 1'b1;
      end else begin
        if (abort_at == n + 1) abort = 1'b1;
        if (poke && n == 3) begin
          cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = 17'h1FFFF;
          cfg_len = 5'd1; cfg_loops = 8'd7; cfg_stop_on_fail = 1'b1;
        end
        @(posedge clk); #1;
        abort = 1'b0; cfg_we = 1'b0;
        n++;
      end
    end
    w = sb_q.pop_front();
    check_eq("done_seen", got_done, 1);
    check_eq("latency", n, w.lat);
    check_eq("pass", pass, w.pass);
    check_eq("fail_cnt", fail_cnt, w.fcnt);
    check_eq("first_fail_idx", first_fail_idx, w.fidx);
    check_eq("first_fail_loop", first_fail_loop, w.floop);
    if (w.chkx) check_eq("dut_x_at_fin", dut_x, w.x);
    check_eq("dut_rst_profile", prof_bad, 0);
    check_eq("busy_in_run", busy_bad, 0);
    @(negedge clk);
    check_eq("done_pulse_width", done, 0);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_dut_rst", dut_rst, 1);
    check_eq("pass_held", pass, w.pass);
  endtask

  function automatic logic [15:0] misr_ref(input logic [15:0] s, input logic [15:0] d);
    logic [15:0] r;
    for (int i = 15; i > 0; i--) r[i] = s[i-1];
    r[0] = 1'b0;
    if (s[15]) begin
      r[12] = ~r[12]; r[3] = ~r[3]; r[1] = ~r[1]; r[0] = ~r[0];
    end
    return r ^ d;
  endfunction

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = 4'd0; cfg_wdata = 17'd0; cfg_len = 5'd0;
    cfg_loops = 8'd0; cfg_stop_on_fail = 1'b0; start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_pass", pass, 0);
    check_eq("rst_dut_rst", dut_rst, 1);
    check_eq("rst_dut_x", dut_x, 0);
    check_eq("rst_fail_cnt", fail_cnt, 0);
    check_eq("rst_ffidx", first_fail_idx, 0);
    check_eq("rst_ffloop", first_fail_loop, 0);
    check_eq("rst_signature", signature, 0);

    load_ref(16);
    // Clean run, one pass.
    run_prog(5'd4, 8'd1, 1'b0, -1, 1'b0, mk(6, 1, 0, 0, 0, 1, stim_of(3)));
`ifndef FSEQ_MISR_EN
    check_eq("signature_tied", signature, 0);
`endif
    // Length clamp to DEPTH; writes and cfg changes during the run are ignored.
    run_prog(5'd20, 8'd1, 1'b0, -1, 1'b1, mk(18, 1, 0, 0, 0, 1, stim_of(15)));
    // Zero passes behaves as one; entry 0 must still hold its original content.
    run_prog(5'd4, 8'd0, 1'b0, -1, 1'b0, mk(6, 1, 0, 0, 0, 1, stim_of(3)));

    // Multi-pass fault at entry 2.
    wr(2, 1'b1, ref_y(stim_of(2)) ^ 9'h100, stim_of(2));
    run_prog(5'd4, 8'd3, 1'b0, -1, 1'b0, mk(14, 0, 3, 2, 0, 1, stim_of(3)));

    // Stop on first fail at entry 1.
    wr(2, 1'b1, ref_y(stim_of(2)), stim_of(2));
    wr(1, 1'b1, ref_y(stim_of(1)) ^ 9'h001, stim_of(1));
    run_prog(5'd8, 8'd1, 1'b1, -1, 1'b0, mk(5, 0, 1, 1, 0, 1, stim_of(2)));

    // Abort at E0+4.
    wr(1, 1'b1, ref_y(stim_of(1)), stim_of(1));
    run_prog(5'd4, 8'd1, 1'b0, 4, 1'b0, mk(4, 0, 0, 0, 0, 1, stim_of(1)));

    // Empty program.
    run_prog(5'd0, 8'd5, 1'b0, -1, 1'b0, mk(0, 1, 0, 0, 0, 0, 7'd0));

    // Trojan exposure: only reachable if the DUT is never reset between passes.
    troj_mode = 1'b1;
    wr(0, 1'b1, 9'h0AA, 7'h01);
    wr(1, 1'b1, 9'h0AA, 7'h03);
    run_prog(5'd2, 8'd4, 1'b0, -1, 1'b0, mk(10, 0, 4, 0, 2, 1, 7'h03));
    troj_mode = 1'b0;

    // Asynchronous reset mid-run, then rerun to show the program survived.
    load_ref(4);
    wr(0, 1'b1, ref_y(stim_of(0)) ^ 9'h004, stim_of(0));
    @(negedge clk);
    cfg_len = 5'd4; cfg_loops = 8'd1; cfg_stop_on_fail = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("pre_rst_fail_cnt", fail_cnt, 1);
    check_eq("pre_rst_dut_rst", dut_rst, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_done", done, 0);
    check_eq("mid_rst_pass", pass, 0);
    check_eq("mid_rst_dut_rst", dut_rst, 1);
    check_eq("mid_rst_dut_x", dut_x, 0);
    check_eq("mid_rst_fail_cnt", fail_cnt, 0);
    check_eq("mid_rst_ffidx", first_fail_idx, 0);
    check_eq("mid_rst_ffloop", first_fail_loop, 0);
    check_eq("mid_rst_signature", signature, 0);
    @(negedge clk);
    rst = 1'b0;
    run_prog(5'd4, 8'd1, 1'b0, -1, 1'b0, mk(6, 0, 1, 0, 0, 1, stim_of(3)));

`ifdef FSEQ_MISR_EN
    begin
      logic [15:0] s;
      zero_mode = 1'b1;
      for (int i = 0; i < 4; i++) wr(i, 1'b1, 9'h000, stim_of(i));
      run_prog(5'd4, 8'd1, 1'b0, -1, 1'b0, mk(6, 1, 0, 0, 0, 1, stim_of(3)));
      s = 16'hFFFF;
      for (int i = 0; i < 4; i++) s = misr_ref(s, 16'h0000);
      check_eq("misr_signature", signature, s);
      zero_mode = 1'b0;
    end
`endif

    check_eq("scoreboard_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fsm_vector_sequencer.md
Name: fsm_vector_sequencer

Overview:
Programmable test controller for the team's benchmark FSMs, such as the 7-input/9-output controller class.
- Holds a small vector memory of stimulus, expected response and check bit.
- Resets the FSM under test, streams vectors at one per cycle and compares responses.
- Repeats the program for a configurable number of passes without re-resetting the DUT, so count-triggered payloads can be exposed.
- Reports pass/fail, mismatch count and first-failure location.

Parameters:
XW, 7, DUT input width
YW, 9, DUT output width
DEPTH, 16, vector memory entries
AW, 4, address width (clog2(DEPTH))
CNTW, 16, fail counter width

Ports:
clk  in  1  clock; sequencer acts on rising edge (DUT registers on falling edge)
rst  in  1  reset, asynchronous, active-high
cfg_we  in  1  vector memory write strobe
cfg_addr  in  AW  write address
cfg_wdata  in  1+YW+XW  entry {chk, exp[YW-1:0], stim[XW-1:0]}
cfg_len  in  AW+1  vectors per pass, 0..DEPTH
cfg_loops  in  8  number of passes
cfg_stop_on_fail  in  1  end run on first mismatch
start  in  1  run request, sampled in IDLE
abort  in  1  terminate run
busy  out  1  high in every state except IDLE
done  out  1  single-cycle pulse in FIN
pass  out  1  fail_cnt==0 and no abort; valid from FIN until next start
dut_rst  out  1  reset to FSM under test
dut_x  out  XW  stimulus to DUT
dut_y  in  YW  DUT response
fail_cnt  out  CNTW  mismatches in run, saturating
first_fail_idx  out  AW  entry index of first mismatch
first_fail_loop  out  8  pass index (from 0) of first mismatch
signature  out  16  response signature (optional feature)

Behaviour:
- Reset values: busy=0, done=0, pass=0, dut_rst=1, dut_x=0, fail_cnt=0, first_fail_idx=0, first_fail_loop=0, signature=0. All counters are 0 and state is IDLE.
- Memory writes are accepted only in IDLE; writes while busy are ignored.
- Memory contents are not cleared by rst.
- Run parameters:
  - cfg_len is clamped to DEPTH.
  - cfg_loops=0 is treated as 1.
  - L = clamped length, P = passes, T = L*P.
  - cfg_* are captured at start; later changes do not affect the run.
- States: IDLE, DRST, RUN, DRAIN, FIN.
- IDLE:
  - dut_rst=1.
  - start with L>0 -> DRST; clears fail_cnt, first_fail_*, signature and pass.
  - start with L=0 -> FIN directly; pass=1.
  - start while busy is ignored.
- DRST:
  - Lasts 2 cycles with dut_rst=1 and dut_x=0.
  - At the 2nd edge: -> RUN, dut_rst<=0, dut_x<=stim[0].
- RUN (start sampled at edge E0):
  - Vector k is driven at edge E0+2+k.
  - Its dut_y is compared at edge E0+3+k, on the same edge that drives vector k+1.
  - Mismatch = chk && (dut_y != exp).
  - Index wraps L-1 -> 0 and increments the pass counter.
  - The DUT is NOT reset between passes.
  - After driving vector T-1 -> DRAIN.
- DRAIN: compares the last vector, then -> FIN.
- FIN:
  - Lasts one cycle; done=1; pass updated.
  - dut_x holds its last value.
  - Then -> IDLE, where dut_rst returns to 1.
  - done is high in the cycle after edge E0+T+2.
- Mismatch handling:
  - fail_cnt increments and saturates at all-ones.
  - On the first mismatch, first_fail_idx and first_fail_loop are latched.
  - With cfg_stop_on_fail=1, the first mismatch -> FIN at the next edge; the vector driven on that edge is not compared.
- abort:
  - In DRST, RUN or DRAIN: -> FIN at the next edge; pass=0; the in-flight compare is discarded.
  - In IDLE or FIN: ignored.
- Simultaneous abort and mismatch: the mismatch is counted; abort wins the transition.
- rst mid-run: immediate return to reset values; the DUT is held in reset.

Optional Feature:
FSEQ_MISR_EN
- Defined:
  - A 16-bit MISR (polynomial x^16+x^12+x^3+x+1, seed 0xFFFF at start) folds zero-extended dut_y on every compare edge, regardless of chk.
  - signature holds its value after FIN.
- Undefined: signature tied to 0 and no MISR logic.

Decomposition:
- Package fseq_pkg:
  - State enum.
  - Entry field offsets and widths (STIM_LSB, EXP_LSB, CHK_BIT).
  - MISR polynomial and seed constants.
- One sub-module, fseq_vec_mem:
  - DEPTH x (1+YW+XW) register file.
  - Synchronous write, combinational read.

Test Plan:
- Clean run: 4 vectors with chk=1 and correct exp; cfg_len=4, cfg_loops=1 -> done in the cycle after E0+6; pass=1; fail_cnt=0; dut_rst low from E0+2 to FIN.
- Multi-pass fault: exp of entry 2 wrong; len=4, loops=3, stop=0 -> fail_cnt=3, first_fail_idx=2, first_fail_loop=0, pass=0.
- Trojan exposure: DUT model that diverts after its 5th s1 visit; 2-vector loop revisiting s1, loops=4 -> first_fail_loop=2; proves no DUT reset between passes.
- Stop-on-fail: mismatch at entry 1, stop=1, len=8 -> done in the cycle after E0+5; fail_cnt=1; dut_x equals stim[2] at FIN.
- Boundaries: len=0 -> done in the cycle after E0, pass=1, dut_rst stays 1. abort at E0+4 -> done next cycle, pass=0. rst at E0+4 -> all outputs return to reset values immediately.
- FSEQ_MISR_EN: all-zero dut_y for 4 compares -> signature equals the reference-model value from seed 0xFFFF; without the macro, signature=0.
